pong_match_ctrl: RTL and testbench
==================================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of paddles/scorers; legal range 2..4.
REQ-002 Parameter SCORE_W, default 4, width of each score counter in bits.
REQ-003 Parameter WIN_SCORE, default 7, score that ends the match immediately; legal range 1..2^SCORE_W-1.
REQ-004 Parameter SERVE_DLY, default 200, number of tick pulses between entering SERVE and the serve pulse; legal range >=1.
REQ-005 Derived constant PW = max(1, clog2(NUM_PLAYERS)), the player-index width.
REQ-006 clk  input  1  system clock; sole clock of the block.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 tick  input  1  single-cycle timebase strobe, e.g. 100 Hz.
REQ-009 start  input  1  single-cycle request to begin a new match.
REQ-010 pause  input  1  single-cycle pause/resume toggle request.
REQ-011 time_up  input  1  single-cycle strobe from the match countdown timer.
REQ-012 miss  input  NUM_PLAYERS  bit i pulses for one cycle when player i lets the ball past.
REQ-013 stop  output  1  freezes ball/paddle motion; high in every state except PLAY.
REQ-014 serve  output  1  one-cycle pulse that launches a new ball.
REQ-015 serve_to  output  PW  index of the player the ball is served toward.
REQ-016 scores  output  NUM_PLAYERS*SCORE_W  packed; player i occupies bits [i*SCORE_W +: SCORE_W].
REQ-017 state  output  3  current state encoding.
REQ-018 winner  output  PW  index of the winning player; meaningful in OVER only.
REQ-019 winner_valid  output  1  high in OVER when a unique winner exists.
REQ-020 timer_run  output  1  enables the external countdown timer; high in SERVE and PLAY.

Function
REQ-021 States and encodings SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4; all outputs are registered or decoded from registered state only.
REQ-022 IDLE: on start, clear all scores, set serve_to=0, clear the delay counter, and go to SERVE.
REQ-023 SERVE: the delay counter SHALL increment only on cycles where tick=1.
REQ-024 SERVE: on the tick that brings the count to SERVE_DLY, go to PLAY and assert serve for exactly the first PLAY cycle.
REQ-025 PLAY, miss!=0 and not all bits set: each player j with miss[j]=0 gains +1, saturating at 2^SCORE_W-1.
REQ-026 PLAY, miss!=0 and not all bits set: serve_to is set to the lowest set index of miss, and the state goes to SERVE with the counter cleared.
REQ-027 PLAY with all miss bits set simultaneously: no score change, serve_to unchanged, go to SERVE.
REQ-028 Score latency: updated scores SHALL be visible on the cycle after the miss is sampled.
REQ-029 Win check: if any updated score is >= WIN_SCORE, go to OVER instead of SERVE, with winner = highest-scoring index (lowest index on tie) and winner_valid=1 only if that maximum is unique.
REQ-030 time_up in SERVE, PLAY or PAUSE: go to OVER and compute winner and winner_valid from the current scores using the REQ-029 rule.
REQ-031 time_up SHALL take priority over miss and pause in the same cycle; the miss is discarded.
REQ-032 pause in PLAY: go to PAUSE.
REQ-033 pause in PAUSE: return to PLAY without re-serving; scores and serve_to are held.
REQ-034 pause in IDLE, SERVE or OVER SHALL be ignored.
REQ-035 miss outside PLAY SHALL be ignored.
REQ-036 OVER: hold scores, winner and winner_valid.
REQ-037 OVER: on start, behave exactly as IDLE+start (REQ-022).
REQ-038 start in SERVE, PLAY or PAUSE SHALL be ignored.
REQ-039 The delay counter SHALL be sized to hold SERVE_DLY and SHALL never wrap.
REQ-040 An unused state encoding (5..7) SHALL return to IDLE on the next clock.

Reset
REQ-041 On rst=1 at a clk edge: state=IDLE, all scores=0, serve_to=0, winner=0, winner_valid=0, serve=0, delay counter=0.
REQ-042 After reset: stop=1 and timer_run=0.
REQ-043 Reset SHALL override all other inputs, including mid-SERVE and mid-PLAY; no serve pulse may follow reset.

Verification
REQ-044 Defaults; rst, then start, then 200 ticks -> one serve pulse, state=2, stop=0, scores=0.
REQ-045 NUM_PLAYERS=2; PLAY, miss=2'b01 -> next cycle scores[7:4]=1, scores[3:0]=0, serve_to=0, state=1; miss=2'b11 -> no score change.
REQ-046 WIN_SCORE=7; player 1 at 6, miss=2'b01 -> state=4, winner=1, winner_valid=1, stop=1; start -> scores=0, state=1.
REQ-047 Scores 3/3 with time_up and miss=2'b10 in the same cycle -> state=4, scores unchanged, winner=0, winner_valid=0.
REQ-048 pause in PLAY -> state=3, miss ignored, timer_run=0; pause again -> state=2, serve not pulsed.
REQ-049 NUM_PLAYERS=4, SCORE_W=2; repeated miss=4'b0001 -> players 1..3 saturate at 3, and the match ends when a score reaches WIN_SCORE (e.g. WIN_SCORE=3 -> OVER with winner=1, winner_valid=0).

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve / play / pause / game-over, keeps
// per-player scores, and decides the winner on a win score or on time-up.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DLY   = 200,
  localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           time_up,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic                           stop,
  output logic                           serve,
  output logic [PW-1:0]                  serve_to,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [2:0]                     state,
  output logic [PW-1:0]                  winner,
  output logic                           winner_valid,
  output logic                           timer_run
);

  // Counter is wide enough to hold SERVE_DLY itself, so it never wraps.
  localparam int CW = $clog2(SERVE_DLY + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0]      DLY_V     = CW'(SERVE_DLY);

  typedef logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_vec_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Every player that did not miss gains one point, saturating at the max.
  function automatic score_vec_t bump_scores(input score_vec_t sc,
                                             input logic [NUM_PLAYERS-1:0] m);
    score_vec_t res;
    res = sc;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (!m[j] && (sc[j] != SCORE_MAX)) begin
        res[j] = sc[j] + SCORE_W'(1'b1);
      end else begin
        res[j] = sc[j];
      end
    end
    return res;
  endfunction

  // Lowest index whose miss bit is set; the ball is served toward that player.
  function automatic logic [PW-1:0] lowest_miss(input logic [NUM_PLAYERS-1:0] m);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when any score has reached the match-ending value.
  function automatic logic any_win(input score_vec_t sc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (sc[i] >= WIN_V) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Returns {unique, index}: highest score, lowest index on a tie.
  function automatic logic [PW:0] pick_winner(input score_vec_t sc);
    logic [SCORE_W-1:0] best;
    logic [PW-1:0]      idx;
    logic               dup;
    best = sc[0];
    idx  = '0;
    dup  = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (sc[i] > best) begin
        best = sc[i];
        idx  = PW'(i);
        dup  = 1'b0;
      end else if (sc[i] == best) begin
        dup = 1'b1;
      end else begin
        dup = dup;
      end
    end
    return {~dup, idx};
  endfunction

  state_t             state_r, state_nxt_s;
  score_vec_t         scores_r, scores_nxt_s, bumped_s;
  logic [PW-1:0]      serve_to_r, serve_to_nxt_s, lowest_s;
  logic [PW-1:0]      winner_r, winner_nxt_s;
  logic               wv_r, wv_nxt_s;
  logic               serve_r, serve_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic               stop_r, timer_run_r;
  logic [PW:0]        pick_cur_s, pick_new_s;
  logic               miss_any_s, miss_all_s, win_hit_s;

  assign bumped_s   = bump_scores(scores_r, miss);
  assign lowest_s   = lowest_miss(miss);
  assign win_hit_s  = any_win(bumped_s);
  assign pick_cur_s = pick_winner(scores_r);
  assign pick_new_s = pick_winner(bumped_s);
  assign miss_any_s = (miss != '0);
  assign miss_all_s = (miss == {NUM_PLAYERS{1'b1}});

  // Next-state and next-register computation for the match sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    scores_nxt_s   = scores_r;
    serve_to_nxt_s = serve_to_r;
    winner_nxt_s   = winner_r;
    wv_nxt_s       = wv_r;
    cnt_nxt_s      = cnt_r;
    serve_nxt_s    = 1'b0;
    case (state_r)
      IDLE, OVER: begin
        if (start) begin
          scores_nxt_s   = '0;
          serve_to_nxt_s = '0;
          winner_nxt_s   = '0;
          wv_nxt_s       = 1'b0;
          cnt_nxt_s      = '0;
          state_nxt_s    = SERVE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SERVE: begin
        if (time_up) begin
          state_nxt_s  = OVER;
          winner_nxt_s = pick_cur_s[PW-1:0];
          wv_nxt_s     = pick_cur_s[PW];
        end else if (tick) begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
          if ((cnt_r + CW'(1'b1)) == DLY_V) begin
            state_nxt_s = PLAY;
            serve_nxt_s = 1'b1;
          end else begin
            state_nxt_s = SERVE;
          end
        end else begin
          state_nxt_s = SERVE;
        end
      end
      PLAY: begin
        if (time_up) begin
          // The timer wins over any simultaneous miss or pause.
          state_nxt_s  = OVER;
          winner_nxt_s = pick_cur_s[PW-1:0];
          wv_nxt_s     = pick_cur_s[PW];
        end else if (miss_all_s) begin
          // Everybody missed: nobody scores, just serve again.
          state_nxt_s = SERVE;
          cnt_nxt_s   = '0;
        end else if (miss_any_s) begin
          scores_nxt_s   = bumped_s;
          serve_to_nxt_s = lowest_s;
          if (win_hit_s) begin
            state_nxt_s  = OVER;
            winner_nxt_s = pick_new_s[PW-1:0];
            wv_nxt_s     = pick_new_s[PW];
          end else begin
            state_nxt_s = SERVE;
            cnt_nxt_s   = '0;
          end
        end else if (pause) begin
          state_nxt_s = PAUSE;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      PAUSE: begin
        if (time_up) begin
          state_nxt_s  = OVER;
          winner_nxt_s = pick_cur_s[PW-1:0];
          wv_nxt_s     = pick_cur_s[PW];
        end else if (pause) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; stop/timer_run are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      scores_r    <= '0;
      serve_to_r  <= '0;
      winner_r    <= '0;
      wv_r        <= 1'b0;
      serve_r     <= 1'b0;
      cnt_r       <= '0;
      stop_r      <= 1'b1;
      timer_run_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      scores_r    <= scores_nxt_s;
      serve_to_r  <= serve_to_nxt_s;
      winner_r    <= winner_nxt_s;
      wv_r        <= wv_nxt_s;
      serve_r     <= serve_nxt_s;
      cnt_r       <= cnt_nxt_s;
      stop_r      <= (state_nxt_s != PLAY);
      timer_run_r <= (state_nxt_s == SERVE) || (state_nxt_s == PLAY);
    end
  end

  assign state        = state_r;
  assign scores       = scores_r;
  assign serve_to     = serve_to_r;
  assign winner       = winner_r;
  assign winner_valid = wv_r;
  assign serve        = serve_r;
  assign stop         = stop_r;
  assign timer_run    = timer_run_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: two configurations, a behavioural
// match model compared every cycle, plus literal expectations.
module tb_pong_match_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: defaults (2 players, 4-bit scores, win 7, 200 ticks)
  logic       rst_a, tick_a, start_a, pause_a, tu_a;
  logic [1:0] miss_a;
  logic       stop_a, serve_a, wv_a, tr_a;
  logic [0:0] serve_to_a, winner_a;
  logic [7:0] scores_a;
  logic [2:0] state_a;

  // Configuration B: 4 players, 2-bit scores, win 3, 2 ticks
  logic       rst_b, tick_b, start_b, pause_b, tu_b;
  logic [3:0] miss_b;
  logic       stop_b, serve_b, wv_b, tr_b;
  logic [1:0] serve_to_b, winner_b;
  logic [7:0] scores_b;
  logic [2:0] state_b;

  pong_match_ctrl dut_a (
    .clk(clk), .rst(rst_a), .tick(tick_a), .start(start_a), .pause(pause_a),
    .time_up(tu_a), .miss(miss_a), .stop(stop_a), .serve(serve_a),
    .serve_to(serve_to_a), .scores(scores_a), .state(state_a),
    .winner(winner_a), .winner_valid(wv_a), .timer_run(tr_a)
  );

  pong_match_ctrl #(.NUM_PLAYERS(4), .SCORE_W(2), .WIN_SCORE(3), .SERVE_DLY(2)) dut_b (
    .clk(clk), .rst(rst_b), .tick(tick_b), .start(start_b), .pause(pause_b),
    .time_up(tu_b), .miss(miss_b), .stop(stop_b), .serve(serve_b),
    .serve_to(serve_to_b), .scores(scores_b), .state(state_b),
    .winner(winner_b), .winner_valid(wv_b), .timer_run(tr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Match model: st 0=idle 1=serve 2=play 3=pause 4=over
  typedef struct packed {
    int st; int cnt; int sto; int win; int wv; int srv;
    logic [3:0][7:0] sc;
  } mdl_t;

  mdl_t ma, mb;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic mdl_t decide(input mdl_t m, input int np);
    int best, idx, cnt;
    best = -1; idx = 0; cnt = 0;
    for (int i = 0; i < np; i++) if (int'(m.sc[i]) > best) begin best = int'(m.sc[i]); idx = i; end
    for (int i = 0; i < np; i++) if (int'(m.sc[i]) == best) cnt++;
    m.win = idx;
    m.wv  = (cnt == 1) ? 1 : 0;
    m.st  = 4;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit r, input bit tk, input bit go,
                                input bit pz, input bit tu, input int ms,
                                input int np, input int sw, input int win, input int dly);
    mdl_t n;
    int all, mx, lo, hit;
    n = m;
    n.srv = 0;
    all = (1 << np) - 1;
    mx  = (1 << sw) - 1;
    if (r) begin
      n = '0;
      return n;
    end
    case (m.st)
      0, 4: if (go) begin
        n.sc = '0; n.sto = 0; n.cnt = 0; n.win = 0; n.wv = 0; n.st = 1;
      end
      1: if (tu) n = decide(n, np);
         else if (tk) begin
           n.cnt = m.cnt + 1;
           if (n.cnt == dly) begin n.st = 2; n.srv = 1; end
         end
      2: if (tu) n = decide(n, np);
         else if (ms == all) begin n.st = 1; n.cnt = 0; end
         else if (ms != 0) begin
           lo = -1; hit = 0;
           for (int j = 0; j < np; j++) begin
             if (ms[j]) begin
               if (lo < 0) lo = j;
             end else if (int'(n.sc[j]) < mx) begin
               n.sc[j] = n.sc[j] + 8'd1;
             end
           end
           for (int j = 0; j < np; j++) if (int'(n.sc[j]) >= win) hit = 1;
           n.sto = lo;
           if (hit != 0) n = decide(n, np);
           else begin n.st = 1; n.cnt = 0; end
         end
         else if (pz) n.st = 3;
      3: if (tu) n = decide(n, np);
         else if (pz) n.st = 2;
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic int pack(input mdl_t m, input int np, input int sw);
    int e;
    e = 0;
    for (int i = 0; i < np; i++) e = e | (int'(m.sc[i]) << (i * sw));
    return e;
  endfunction

  // Advance both models on each active edge, compare on the falling edge.
  always begin
    @(posedge clk);
    ma = step(ma, rst_a, tick_a, start_a, pause_a, tu_a, int'(miss_a), 2, 4, 7, 200);
    mb = step(mb, rst_b, tick_b, start_b, pause_b, tu_b, int'(miss_b), 4, 2, 3, 2);
    @(negedge clk);
    if (chk_en) begin
      chk("a_state", int'(state_a), ma.st);
      chk("a_scores", int'(scores_a), pack(ma, 2, 4));
      chk("a_serve", int'(serve_a), ma.srv);
      chk("a_serve_to", int'(serve_to_a), ma.sto);
      chk("a_winner", int'(winner_a), ma.win);
      chk("a_winner_valid", int'(wv_a), ma.wv);
      chk("a_stop", int'(stop_a), (ma.st != 2) ? 1 : 0);
      chk("a_timer_run", int'(tr_a), (ma.st == 1 || ma.st == 2) ? 1 : 0);
      chk("b_state", int'(state_b), mb.st);
      chk("b_scores", int'(scores_b), pack(mb, 4, 2));
      chk("b_serve", int'(serve_b), mb.srv);
      chk("b_serve_to", int'(serve_to_b), mb.sto);
      chk("b_winner", int'(winner_b), mb.win);
      chk("b_winner_valid", int'(wv_b), mb.wv);
      chk("b_stop", int'(stop_b), (mb.st != 2) ? 1 : 0);
      chk("b_timer_run", int'(tr_b), (mb.st == 1 || mb.st == 2) ? 1 : 0);
    end
  end

  task automatic stp_a();
    @(posedge clk); #1;
    rst_a = 1'b0; tick_a = 1'b0; start_a = 1'b0; pause_a = 1'b0; tu_a = 1'b0; miss_a = 2'b00;
  endtask

  task automatic stp_b();
    @(posedge clk); #1;
    rst_b = 1'b0; tick_b = 1'b0; start_b = 1'b0; pause_b = 1'b0; tu_b = 1'b0; miss_b = 4'b0000;
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) begin tick_a = 1'b1; stp_a(); end
  endtask

  task automatic miss_a_do(input logic [1:0] v);
    miss_a = v; stp_a();
  endtask

  task automatic serve_miss_b(input logic [3:0] v);
    tick_b = 1'b1; stp_b();
    tick_b = 1'b1; stp_b();
    chk("b_lit_play", int'(state_b), 2);
    miss_b = v; stp_b();
  endtask

  initial begin
    ma = '0; mb = '0;
    rst_a = 1'b1; tick_a = 1'b0; start_a = 1'b0; pause_a = 1'b0; tu_a = 1'b0; miss_a = 2'b00;
    rst_b = 1'b1; tick_b = 1'b0; start_b = 1'b0; pause_b = 1'b0; tu_b = 1'b0; miss_b = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; chk_en = 1'b1;
    chk("lit_rst_state", int'(state_a), 0);
    chk("lit_rst_stop", int'(stop_a), 1);
    chk("lit_rst_timer_run", int'(tr_a), 0);
    chk("lit_rst_scores", int'(scores_a), 0);

    // Start, then 200 ticks spaced by idle cycles
    start_a = 1'b1; stp_a();
    chk("lit_start_state", int'(state_a), 1);
    chk("lit_start_timer_run", int'(tr_a), 1);
    for (int i = 0; i < 200; i++) begin
      if (i > 0) stp_a();
      tick_a = 1'b1; stp_a();
      if (i == 198) chk("lit_no_early_serve", int'(state_a), 1);
    end
    chk("lit_serve_pulse", int'(serve_a), 1);
    chk("lit_play_state", int'(state_a), 2);
    chk("lit_play_stop", int'(stop_a), 0);
    stp_a();
    chk("lit_serve_once", int'(serve_a), 0);

    // Player 0 misses: player 1 scores
    miss_a_do(2'b01);
    chk("lit_miss01_scores", int'(scores_a), 8'h10);
    chk("lit_miss01_state", int'(state_a), 1);
    ticks_a(200);
    miss_a_do(2'b11);
    chk("lit_miss11_scores", int'(scores_a), 8'h10);
    ticks_a(200);
    miss_a_do(2'b10);
    chk("lit_miss10_scores", int'(scores_a), 8'h11);
    chk("lit_miss10_serve_to", int'(serve_to_a), 1);

    // Pause and resume
    ticks_a(200);
    pause_a = 1'b1; stp_a();
    chk("lit_pause_state", int'(state_a), 3);
    chk("lit_pause_timer_run", int'(tr_a), 0);
    miss_a_do(2'b01);
    chk("lit_pause_miss", int'(scores_a), 8'h11);
    start_a = 1'b1; stp_a();
    pause_a = 1'b1; stp_a();
    chk("lit_resume_state", int'(state_a), 2);
    chk("lit_resume_no_serve", int'(serve_a), 0);
    stp_a();

    // Pause ignored in SERVE, then drive player 1 to the win
    miss_a_do(2'b01);
    pause_a = 1'b1; stp_a();
    chk("lit_serve_pause_ignored", int'(state_a), 1);
    for (int k = 0; k < 5; k++) begin ticks_a(200); miss_a_do(2'b01); end
    chk("lit_win_scores", int'(scores_a), 8'h71);
    chk("lit_win_state", int'(state_a), 4);
    chk("lit_win_winner", int'(winner_a), 1);
    chk("lit_win_valid", int'(wv_a), 1);
    chk("lit_win_stop", int'(stop_a), 1);
    miss_a_do(2'b10);
    pause_a = 1'b1; stp_a();
    tu_a = 1'b1; stp_a();
    chk("lit_over_hold", int'(scores_a), 8'h71);
    start_a = 1'b1; stp_a();
    chk("lit_restart_scores", int'(scores_a), 0);
    chk("lit_restart_state", int'(state_a), 1);

    // Reach 3/3, then time_up with a simultaneous miss
    for (int k = 0; k < 3; k++) begin ticks_a(200); miss_a_do(2'b01); end
    for (int k = 0; k < 3; k++) begin ticks_a(200); miss_a_do(2'b10); end
    ticks_a(200);
    tu_a = 1'b1; miss_a = 2'b10; stp_a();
    chk("lit_tu_state", int'(state_a), 4);
    chk("lit_tu_scores", int'(scores_a), 8'h33);
    chk("lit_tu_valid", int'(wv_a), 0);

    // Reset mid-SERVE: no serve may follow
    start_a = 1'b1; stp_a();
    ticks_a(150);
    rst_a = 1'b1; tick_a = 1'b1; stp_a();
    chk("lit_rst_serve_state", int'(state_a), 0);
    ticks_a(250);
    chk("lit_rst_serve_idle", int'(state_a), 0);

    // Reset mid-PLAY
    start_a = 1'b1; stp_a();
    ticks_a(200);
    miss_a_do(2'b10);
    ticks_a(200);
    rst_a = 1'b1; stp_a();
    chk("lit_rst_play_scores", int'(scores_a), 0);

    // time_up in SERVE and in PAUSE
    start_a = 1'b1; stp_a();
    ticks_a(50);
    tu_a = 1'b1; stp_a();
    chk("lit_tu_serve", int'(state_a), 4);
    start_a = 1'b1; stp_a();
    ticks_a(200);
    pause_a = 1'b1; stp_a();
    tu_a = 1'b1; stp_a();
    chk("lit_tu_pause", int'(state_a), 4);
    repeat (3) stp_a();

    // Four-player configuration
    start_b = 1'b1; stp_b();
    serve_miss_b(4'b0001);
    chk("b_lit_1", int'(scores_b), 8'h54);
    serve_miss_b(4'b0001);
    chk("b_lit_2", int'(scores_b), 8'hA8);
    serve_miss_b(4'b0001);
    chk("b_lit_3", int'(scores_b), 8'hFC);
    chk("b_lit_over", int'(state_b), 4);
    chk("b_lit_winner", int'(winner_b), 1);
    chk("b_lit_valid", int'(wv_b), 0);
    start_b = 1'b1; stp_b();
    serve_miss_b(4'b0110);
    chk("b_lit_0110", int'(scores_b), 8'h41);
    chk("b_lit_0110_to", int'(serve_to_b), 1);
    serve_miss_b(4'b1111);
    chk("b_lit_1111", int'(scores_b), 8'h41);
    serve_miss_b(4'b1000);
    chk("b_lit_1000", int'(scores_b), 8'h56);
    chk("b_lit_1000_to", int'(serve_to_b), 3);
    serve_miss_b(4'b0011);
    chk("b_lit_0011", int'(scores_b), 8'hA6);
    serve_miss_b(4'b0001);
    chk("b_lit_end", int'(scores_b), 8'hFA);
    chk("b_lit_end_winner", int'(winner_b), 2);
    repeat (3) stp_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
